// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: control wrapper around a UART receiver.
// Owns the applied RX configuration, stages config writes until the line is idle,
// watches frame activity, buffers received bytes in a FWFT FIFO with a valid/ready
// output and flags overrun, broken frames and end-of-burst idle.
module uart_rx_ctrl #(
  parameter int unsigned BusWidth   = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IDLE_BITS  = 10
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cfg_wr_i,
  input  logic [4:0]          cfg_prescale_i,
  input  logic                cfg_par_en_i,
  input  logic                cfg_par_typ_i,
  output logic                cfg_busy_o,
  input  logic                rx_in_i,
  input  logic [BusWidth-1:0] rx_p_data_i,
  input  logic                rx_data_valid_i,
  output logic [4:0]          prescale_o,
  output logic                par_en_o,
  output logic                par_typ_o,
  output logic [BusWidth-1:0] out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                overrun_o,
  input  logic                ovr_clr_i,
  output logic                line_err_o,
  output logic                frame_timeout_o
);

  localparam int unsigned PreW  = 5;
  localparam int unsigned WdogW = 9;
  localparam int unsigned IdleW = 16;
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  typedef struct packed {
    logic [PreW-1:0] prescale;
    logic            par_en;
    logic            par_typ;
  } cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_APPLY = 2'd2
  } state_e;

  localparam cfg_t CfgReset = '{prescale: PreW'(8), par_en: 1'b1, par_typ: 1'b0};

  // Control state
  state_e           state_q;
  cfg_t             shadow_q;
  cfg_t             applied_q;
  logic             busy_q;
  logic [WdogW-1:0] wdog_q;
  logic [IdleW-1:0] idle_cnt_q;
  logic             got_byte_q;
  logic             line_err_q;
  logic             frame_to_q;

  // FIFO state
  logic [BusWidth-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [PtrW-1:0]     wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_d;
  logic                out_valid_q;
  logic [BusWidth-1:0] out_data_q;
  logic [BusWidth-1:0] head_d;
  logic                overrun_q;

  // Combinational helpers
  logic             cfg_legal;
  cfg_t             cfg_req;
  logic [IdleW-1:0] frame_lim;
  logic [IdleW-1:0] idle_lim;
  logic [PtrW-1:0]  fifo_cnt;
  logic             fifo_full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [AddrW-1:0] head_idx;

  assign cfg_legal = cfg_wr_i && ((cfg_prescale_i == PreW'(8)) || (cfg_prescale_i == PreW'(16)));
  assign cfg_req   = '{prescale: cfg_prescale_i, par_en: cfg_par_en_i, par_typ: cfg_par_typ_i};

  // Watchdog limit: start + data + optional parity + stop + one spare bit-time, minus one
  assign frame_lim = IdleW'((IdleW'(BusWidth) + IdleW'(3) + IdleW'(applied_q.par_en))
                            * IdleW'(applied_q.prescale) - IdleW'(1));
  assign idle_lim  = IdleW'(IdleW'(IDLE_BITS) * IdleW'(applied_q.prescale) - IdleW'(1));

  assign fifo_cnt  = PtrW'(wr_ptr_q - rd_ptr_q);
  assign fifo_full = (fifo_cnt == PtrW'(FIFO_DEPTH));
  assign pop       = out_valid_q && out_ready_i;
  assign push      = rx_data_valid_i && (!fifo_full || pop);
  assign drop      = rx_data_valid_i && fifo_full && !pop;

  // Next FIFO pointers and the head byte to present after this cycle's push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = PtrW'(wr_ptr_q + PtrW'(1));
    if (pop)  rd_ptr_d = PtrW'(rd_ptr_q + PtrW'(1));
    head_idx = rd_ptr_d[AddrW-1:0];
    head_d   = mem_q[head_idx];
    if (push && (head_idx == wr_ptr_q[AddrW-1:0])) head_d = rx_p_data_i;
    if (wr_ptr_d == rd_ptr_d) head_d = '0;
  end

  // Control FSM with config staging, watchdog, idle counter and event pulses
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      shadow_q   <= CfgReset;
      applied_q  <= CfgReset;
      busy_q     <= 1'b0;
      wdog_q     <= '0;
      idle_cnt_q <= '0;
      got_byte_q <= 1'b0;
      line_err_q <= 1'b0;
      frame_to_q <= 1'b0;
    end else begin
      line_err_q <= 1'b0;
      frame_to_q <= 1'b0;

      if (!rx_in_i) begin
        idle_cnt_q <= '0;
      end else if ((state_q == ST_IDLE) && (idle_cnt_q != '1)) begin
        idle_cnt_q <= IdleW'(idle_cnt_q + IdleW'(1));
      end

      if (cfg_legal) begin
        shadow_q <= cfg_req;
        busy_q   <= 1'b1;
      end

      // End-of-burst idle fires once per burst; a new byte in the same cycle re-arms it
      if (rx_in_i && got_byte_q && (idle_cnt_q == idle_lim)) begin
        frame_to_q <= 1'b1;
        got_byte_q <= 1'b0;
      end
      if (rx_data_valid_i) got_byte_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (!rx_in_i) begin
            state_q <= ST_FRAME;
            wdog_q  <= '0;
          end else if (busy_q && (idle_cnt_q >= IdleW'(applied_q.prescale))) begin
            state_q <= ST_APPLY;
          end
        end
        ST_FRAME: begin
          if (rx_data_valid_i) begin
            state_q <= ST_IDLE;
          end else if (IdleW'(wdog_q) == frame_lim) begin
            state_q    <= ST_IDLE;
            line_err_q <= 1'b1;
          end else if (wdog_q != '1) begin
            wdog_q <= WdogW'(wdog_q + WdogW'(1));
          end
        end
        ST_APPLY: begin
          applied_q <= shadow_q;
          if (!cfg_legal) busy_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // FIFO storage; stale entries are harmless because pointers define occupancy
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AddrW-1:0]] <= rx_p_data_i;
  end

  // FIFO pointers, registered head/valid and sticky overrun
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= (wr_ptr_d != rd_ptr_d);
      out_data_q  <= head_d;
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (ovr_clr_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign cfg_busy_o      = busy_q;
  assign prescale_o      = applied_q.prescale;
  assign par_en_o        = applied_q.par_en;
  assign par_typ_o       = applied_q.par_typ;
  assign out_data_o      = out_data_q;
  assign out_valid_o     = out_valid_q;
  assign overrun_o       = overrun_q;
  assign line_err_o      = line_err_q;
  assign frame_timeout_o = frame_to_q;

endmodule
